// File: rtl/serial_buff_pkg.sv
// Shared encodings for the serial_buff sequencer: FSM states and cntin code points.
package serial_buff_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_LOAD = 3'd2,
        S_WAIT = 3'd3,
        S_ROT  = 3'd4
    } state_t;

    localparam int         NIB_W        = 4;
    localparam int         CNT_LOAD     = 0;
    localparam logic [1:0] CNT_HOLD_LSB = 2'b01;

endpackage

// File: rtl/serial_buff_ctrl.sv
// Sequences one serial_buff: bit-serial fill, then a latch and nibble-at-a-time drain (or one whole-word beat if MOVIN).
// Latency: last bit accepted at t, latch at t+1, first out_vld at t+2; drain 1 beat per 2 cycles. Optional abort: SERIAL_BUFF_CTRL_ABORT_EN.
module serial_buff_ctrl
    import serial_buff_pkg::*;
#(
    parameter int   NDATA = 128,
    parameter logic MOVIN = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_vld,
    input  logic                     bit_in,
    output logic                     bit_rdy,
    output logic                     ena,
    output logic                     din,
    output logic [$clog2(NDATA)-1:0] cntin,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     done
`ifdef SERIAL_BUFF_CTRL_ABORT_EN
    ,
    input  logic                     abort
`endif
);

    localparam int CW = $clog2(NDATA);
    localparam int KW = CW - $clog2(NIB_W);
    localparam logic [CW-1:0] BIT_LAST  = CW'(NDATA - 1);
    localparam logic [KW-1:0] K_LAST    = KW'(NDATA / NIB_W - 1);
    localparam logic [CW-1:0] CNT_RESET = CW'(1);

    state_t        state_q;
    logic [CW-1:0] bitcnt_q;
    logic [KW-1:0] k_q;
    logic [CW-1:0] cntin_q;
    logic          out_vld_q;
    logic          done_q;

    assign bit_rdy = (state_q == S_IDLE) || (state_q == S_FILL);
    assign ena     = bit_vld & bit_rdy;
    assign din     = bit_in;
    assign cntin   = cntin_q;
    assign out_vld = out_vld_q;
    assign done    = done_q;

    // cntin rests at {k,01} so serial_buff only latches in LOAD and only rotates in ROT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= '0;
            k_q       <= '0;
            cntin_q   <= CNT_RESET;
            out_vld_q <= 1'b0;
            done_q    <= 1'b0;
        end
`ifdef SERIAL_BUFF_CTRL_ABORT_EN
        else if (abort) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= '0;
            k_q       <= '0;
            cntin_q   <= CNT_RESET;
            out_vld_q <= 1'b0;
            done_q    <= 1'b0;
        end
`endif
        else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bit_vld) begin
                        bitcnt_q <= CW'(1);
                        state_q  <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (bit_vld) begin
                        if (bitcnt_q == BIT_LAST) begin
                            bitcnt_q <= '0;
                            cntin_q  <= CW'(CNT_LOAD);
                            state_q  <= S_LOAD;
                        end else begin
                            bitcnt_q <= bitcnt_q + CW'(1);
                        end
                    end
                end
                S_LOAD: begin
                    k_q       <= '0;
                    cntin_q   <= {KW'(0), CNT_HOLD_LSB};
                    out_vld_q <= 1'b1;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    if (out_rdy) begin
                        out_vld_q <= 1'b0;
                        if (MOVIN || (k_q == K_LAST)) begin
                            k_q     <= '0;
                            cntin_q <= CNT_RESET;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            k_q     <= k_q + KW'(1);
                            cntin_q <= {k_q + KW'(1), 2'b00};
                            state_q <= S_ROT;
                        end
                    end
                end
                S_ROT: begin
                    cntin_q   <= {k_q, CNT_HOLD_LSB};
                    out_vld_q <= 1'b1;
                    state_q   <= S_WAIT;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_buff_ctrl.sv
// Directed bench: two controllers (NDATA=128 nibble drain, NDATA=8 MOVIN word drain) driving behavioural serial_buff models.
module tb_serial_buff_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       bit_vld = 1'b0, bit_in = 1'b0, out_rdy = 1'b0;
    logic       bit_rdy, ena, din, out_vld, done;
    logic [6:0] cntin;

    logic       bit_vld1 = 1'b0, bit_in1 = 1'b0, out_rdy1 = 1'b0;
    logic       bit_rdy1, ena1, din1, out_vld1, done1;
    logic [2:0] cntin1;

`ifdef SERIAL_BUFF_CTRL_ABORT_EN
    logic abort = 1'b0, abort1 = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    serial_buff_ctrl #(.NDATA(128), .MOVIN(1'b0)) u_dut (
        .clk(clk), .rst(rst), .bit_vld(bit_vld), .bit_in(bit_in), .bit_rdy(bit_rdy),
        .ena(ena), .din(din), .cntin(cntin), .out_vld(out_vld), .out_rdy(out_rdy), .done(done)
`ifdef SERIAL_BUFF_CTRL_ABORT_EN
        , .abort(abort)
`endif
    );

    serial_buff_ctrl #(.NDATA(8), .MOVIN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .bit_vld(bit_vld1), .bit_in(bit_in1), .bit_rdy(bit_rdy1),
        .ena(ena1), .din(din1), .cntin(cntin1), .out_vld(out_vld1), .out_rdy(out_rdy1), .done(done1)
`ifdef SERIAL_BUFF_CTRL_ABORT_EN
        , .abort(abort1)
`endif
    );

    // serial_buff behaviour: shift in on ena (first bit ends in MSB), latch at cntin==0, rotate left 4 at nonzero multiples of 4.
    logic [127:0] sr0, buf0;
    logic [7:0]   sr1, buf1;
    always @(posedge clk) begin
        if (ena) sr0 <= {sr0[126:0], din};
        if (cntin == 7'd0) buf0 <= sr0;
        else if (cntin[1:0] == 2'b00) buf0 <= {buf0[123:0], buf0[127:124]};
        if (ena1) sr1 <= {sr1[6:0], din1};
        if (cntin1 == 3'd0) buf1 <= sr1;
        else if (cntin1[1:0] == 2'b00) buf1 <= {buf1[3:0], buf1[7:4]};
    end
    wire [3:0] nib = buf0[127:124];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [127:0] w, input bit gaps, input logic hold);
        int ena_hi = 0;
        int din_bad = 0;
        int gap_bad = 0;
        for (int i = 0; i < 128; i++) begin
            if (gaps && i > 0) begin
                int n = $urandom_range(1, 5);
                bit_vld = 1'b0;
                #1;
                if (ena !== 1'b0) gap_bad++;
                repeat (n) tick();
            end
            bit_vld = 1'b1;
            bit_in  = w[127-i];
            #1;
            if (ena === 1'b1) ena_hi++;
            if (din !== bit_in) din_bad++;
            tick();
        end
        bit_vld = hold;
        chk("ena_cycles", ena_hi, 128);
        chk("din_follow", din_bad, 0);
        chk("gap_ena", gap_bad, 0);
        chk("load_cntin", cntin, 0);
        chk("load_vld", out_vld, 0);
        chk("load_rdy", bit_rdy, 0);
        tick();
        chk("first_vld", out_vld, 1);
        chk("first_cntin", cntin, 1);
    endtask

    task automatic drain(input logic [127:0] w, input bit rnd, input int stop_at);
        int b = 0;
        int cyc = 0;
        int viol = 0;
        while (b < stop_at && cyc < 1000) begin
            if (bit_vld && (bit_rdy !== 1'b0 || ena !== 1'b0)) viol++;
            if (out_vld) begin
                chk("nibble", nib, w[127-4*b -: 4]);
                chk("wait_cntin", cntin, 4*b + 1);
                out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_rdy) b++;
            end else begin
                chk("rot_cntin", cntin, 4*b);
                out_rdy = 1'b0;
            end
            if (b == 32) bit_vld = 1'b0;
            tick();
            cyc++;
        end
        out_rdy = 1'b0;
        chk("beats", b, stop_at);
        chk("drain_hold", viol, 0);
    endtask

    task automatic check_done();
        chk("done_pulse", done, 1);
        chk("done_rdy", bit_rdy, 1);
        chk("done_vld", out_vld, 0);
        chk("done_cntin", cntin, 1);
        tick();
        chk("done_clear", done, 0);
    endtask

    logic [127:0] w1, w2, w3;

    initial begin
        w1 = 128'h0123456789ABCDEF0123456789ABCDEF;
        w2 = 128'hFEDCBA9876543210FEDCBA9876543210;
        w3 = 128'h13579BDF2468ACE00F1E2D3C4B5A6978;

        repeat (3) tick();
        rst = 1'b1;
        chk("rst_ena", ena, 0);
        chk("rst_cntin", cntin, 1);
        chk("rst_vld", out_vld, 0);
        chk("rst_rdy", bit_rdy, 1);
        chk("rst_done", done, 0);
        tick();

        send_word(w1, 1'b0, 1'b0);
        chk("first_nib", nib, 0);
        drain(w1, 1'b0, 32);
        check_done();

        send_word(w2, 1'b0, 1'b1);
        drain(w2, 1'b1, 32);
        check_done();

        for (int i = 0; i < 60; i++) begin
            bit_vld = 1'b1;
            bit_in  = 1'b1;
            tick();
        end
        bit_vld = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_cntin", cntin, 1);
        chk("mid_rst_rdy", bit_rdy, 1);
        chk("mid_rst_vld", out_vld, 0);
        send_word(w3, 1'b1, 1'b0);
        drain(w3, 1'b0, 32);
        check_done();

        for (int i = 0; i < 8; i++) begin
            bit_vld1 = 1'b1;
            bit_in1  = w1[127-i] ^ i[0];
            tick();
        end
        bit_vld1 = 1'b0;
        chk("mv_load_cntin", cntin1, 0);
        tick();
        chk("mv_vld", out_vld1, 1);
        chk("mv_word", buf1, {w1[127:120] ^ 8'h55});
        out_rdy1 = 1'b1;
        tick();
        out_rdy1 = 1'b0;
        chk("mv_done", done1, 1);
        chk("mv_vld_off", out_vld1, 0);
        tick();
        chk("mv_done_clear", done1, 0);

`ifdef SERIAL_BUFF_CTRL_ABORT_EN
        send_word(w2, 1'b0, 1'b0);
        drain(w2, 1'b0, 10);
        while (!out_vld) tick();
        abort   = 1'b1;
        out_rdy = 1'b1;
        tick();
        abort   = 1'b0;
        out_rdy = 1'b0;
        chk("ab_vld", out_vld, 0);
        chk("ab_cntin", cntin, 1);
        chk("ab_rdy", bit_rdy, 1);
        chk("ab_done", done, 0);
        tick();
        chk("ab_no_done", done, 0);
        send_word(w1, 1'b0, 1'b0);
        drain(w1, 1'b0, 32);
        check_done();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
